muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit, parametrised in XLEN. Sits beside the single-cycle ALU in EX.
//  Takes one operation per valid/ready handshake, computes it over multiple cycles, and holds the result until the consumer accepts it.
//  The core stalls on in_ready/out_valid. Flush kills the in-flight operation on a branch mispredict or trap.
// PARAMETERS
//  XLEN       32  operand/result width (>=8, even)
//  BITS_PER_CYC 1 radix: bits retired per CALC cycle (1 or 2); XLEN % BITS_PER_CYC == 0
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  flush      in   1     synchronous abort of any operation, accepted or pending
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept a request
//  op         in   3     funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  a          in   XLEN  rs1 operand
//  b          in   XLEN  rs2 operand
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  result; stable while out_valid && !out_ready
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n low): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, internal counters/accumulators=0.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: in_ready=1. On in_valid&&in_ready, latch op/a/b, compute operand signs and magnitudes, and choose the next state:
//    - div-by-zero, b==0 with op[2]=1: DONE. DIV/DIVU result=all ones; REM/REMU result=a.
//    - signed overflow, DIV/REM with a=0x8000..0 and b=all ones: DONE. DIV result=a; REM result=0.
//    - otherwise: CALC, cnt=XLEN/BITS_PER_CYC.
//   CALC: per cycle retire BITS_PER_CYC bits. Multiply is shift-add on magnitudes into a 2*XLEN accumulator.
//    Divide is restoring shift-subtract on magnitudes. cnt decrements; at cnt==1 the next state is DONE.
//   DONE: out_valid=1. Leave for IDLE on out_ready. Result is selected and sign-corrected on entry to DONE (registered).
//  Latency: accept edge E. Normal ops give out_valid from cycle E+XLEN/BITS_PER_CYC+1. Special cases give out_valid at E+1.
//  Sign rules:
//   - MUL: low XLEN bits; sign-independent.
//   - MULH: s*s. MULHSU: s(a)*u(b). MULHU: u*u. Each returns the high XLEN bits of the 2*XLEN product.
//   - Product negated iff the operand signs differ (signed operands only).
//   - Quotient negated iff the signs differ. Remainder takes the sign of a.
//  Handshake:
//   - No new request is accepted in CALC or DONE; in_ready = (state==IDLE).
//   - After an out_ready handshake in DONE, in_ready rises the next cycle, which gives one bubble.
//   - Holding out_ready high in DONE completes the handshake in that same cycle.
//  Flush:
//   - In any state: next state=IDLE, out_valid=0 next cycle, and the result is discarded.
//   - Flush wins over a simultaneous in_valid in IDLE, so no request is accepted.
//   - Flush wins over a simultaneous out_ready in DONE. The consumer must ignore the result in that cycle.
//  Reset mid-CALC: immediate return to IDLE per the async reset values; no partial result is ever visible.
//  Back-pressure: in DONE with out_ready=0, result and out_valid hold indefinitely.
// STRUCTURE
//  Shared package muldiv_pkg:
//   - op localparams (OP_MUL..OP_REMU)
//   - state encoding (ST_IDLE, ST_CALC, ST_DONE)
//   - width helper for cnt: $clog2(XLEN/BITS_PER_CYC+1)
//  Sub-module muldiv_operand_prep (combinational): per-op signedness, abs(a), abs(b),
//   negate-product and negate-quotient/remainder flags, special-case detect. Instantiated once at IDLE accept.
//  Datapath: one 2*XLEN accumulator shared by multiply (product) and divide ({rem,quot}).
// TESTING
//  1 MUL a=7 b=-3 -> after 33 cycles result=0xFFFFFFEB. MULH same operands -> result=0xFFFFFFFF.
//  2 MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1 b=0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV a=-7 b=2 -> quot=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU a=100 b=7 -> 14. REMU -> 2.
//  4 Special cases, each with out_valid one cycle after accept:
//    - DIVU a=5 b=0 -> 0xFFFFFFFF; REM a=5 b=0 -> 5.
//    - DIV a=0x80000000 b=-1 -> 0x80000000; REM with the same operands -> 0.
//  5 Back-pressure: hold out_ready=0 for 10 cycles in DONE -> result is stable and in_valid is not accepted.
//    Then pulse out_ready -> in_ready=1 on the next cycle.
//  6 Flush mid-CALC (cycle 10), and rst_n low mid-CALC:
//    - Flush -> IDLE next cycle and out_valid never rises. A following MUL 3*4 returns 12.
//    - rst_n low -> all outputs immediately at their reset values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM encoding, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_pkg;

    // funct3 encodings of the RV32M operations
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width of the iteration counter; it must hold the value XLEN/BITS_PER_CYC itself
    function automatic int cnt_width(input int xlen, input int bits_per_cyc);
        return $clog2(xlen / bits_per_cyc + 1);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: signedness per op, magnitudes, result-negation flags, special cases.
// Latency: 0 cycles (pure combinational, sampled by the top on the accept edge).
// Backpressure: none; the top only consumes the outputs while accepting a request.
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] a_mag_o,
    output logic [XLEN-1:0] b_mag_o,
    output logic            neg_res_o,
    output logic            neg_rem_o,
    output logic            special_o,
    output logic [XLEN-1:0] special_res_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;
    logic div_zero;
    logic div_ovf;

    // Decode signedness, take magnitudes and flag the cases that bypass iteration
    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV)  || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg    = a_signed & a_i[XLEN-1];
        b_neg    = b_signed & b_i[XLEN-1];

        // INT_MIN negates to itself, which is the correct unsigned magnitude
        a_mag_o  = a_neg ? (~a_i + {{(XLEN-1){1'b0}}, 1'b1}) : a_i;
        b_mag_o  = b_neg ? (~b_i + {{(XLEN-1){1'b0}}, 1'b1}) : b_i;

        // Product / quotient sign differs from magnitudes iff operand signs differ;
        // the remainder follows the dividend.
        neg_res_o = a_neg ^ b_neg;
        neg_rem_o = a_neg;

        div_zero = op_i[2] && (b_i == '0);
        div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (a_i == INT_MIN) && (b_i == '1);

        special_o     = div_zero | div_ovf;
        special_res_o = '0;
        if (div_zero) begin
            // op[1] distinguishes REM/REMU from DIV/DIVU
            special_res_o = op_i[1] ? a_i : '1;
        end else if (div_ovf) begin
            special_res_o = op_i[1] ? '0 : a_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, BITS_PER_CYC bits per cycle.
// Latency: XLEN/BITS_PER_CYC+1 cycles accept-to-out_valid; divide-by-zero/overflow in 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts anything.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int NSTEP = XLEN / BITS_PER_CYC;
    localparam int CW    = cnt_width(XLEN, BITS_PER_CYC);

    // Architectural state
    logic [1:0]        state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [2*XLEN-1:0] acc_q,     acc_d;
    logic [XLEN-1:0]   b_mag_q,   b_mag_d;
    logic [2:0]        op_q,      op_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q,  result_d;

    // Operand conditioning outputs
    logic [XLEN-1:0] prep_a_mag;
    logic [XLEN-1:0] prep_b_mag;
    logic            prep_neg_res;
    logic            prep_neg_rem;
    logic            prep_special;
    logic [XLEN-1:0] prep_special_res;

    // Iteration datapath
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_sub;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_raw;
    logic [XLEN-1:0]   rem_raw;
    logic [XLEN-1:0]   fin_res;
    logic              accept;

    muldiv_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .op_i          (op),
        .a_i           (a),
        .b_i           (b),
        .a_mag_o       (prep_a_mag),
        .b_mag_o       (prep_b_mag),
        .neg_res_o     (prep_neg_res),
        .neg_rem_o     (prep_neg_rem),
        .special_o     (prep_special),
        .special_res_o (prep_special_res)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready && !flush;

    // One CALC cycle: retire BITS_PER_CYC multiplier or quotient bits from the shared accumulator.
    // Multiply holds {product_hi, multiplier}; divide holds {remainder, dividend/quotient}.
    always_comb begin
        acc_step = acc_q;
        rem_sh   = '0;
        rem_sub  = '0;
        mul_sum  = '0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            if (op_q[2]) begin
                rem_sh = acc_step[2*XLEN-1:XLEN-1];
                if (rem_sh >= {1'b0, b_mag_q}) begin
                    rem_sub  = rem_sh - {1'b0, b_mag_q};
                    acc_step = {rem_sub[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
                end else begin
                    acc_step = {rem_sh[XLEN-1:0], acc_step[XLEN-2:0], 1'b0};
                end
            end else begin
                mul_sum  = {1'b0, acc_step[2*XLEN-1:XLEN]} +
                           (acc_step[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
                acc_step = {mul_sum, acc_step[XLEN-1:1]};
            end
        end
    end

    // Final result selection and sign correction, taken from the last iteration's accumulator
    always_comb begin
        prod_fix = neg_res_q ? (~acc_step + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_step;
        quot_raw = acc_step[XLEN-1:0];
        rem_raw  = acc_step[2*XLEN-1:XLEN];
        fin_res  = '0;
        case (op_q)
            OP_MUL:                        fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fin_res = neg_res_q ? (~quot_raw + {{(XLEN-1){1'b0}}, 1'b1}) : quot_raw;
            default:                       fin_res = neg_rem_q ? (~rem_raw + {{(XLEN-1){1'b0}}, 1'b1}) : rem_raw;
        endcase
    end

    // FSM and datapath next-state; flush overrides everything and discards the result
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_mag_d   = b_mag_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = op;
                    b_mag_d   = prep_b_mag;
                    neg_res_d = prep_neg_res;
                    neg_rem_d = prep_neg_rem;
                    if (prep_special) begin
                        state_d  = ST_DONE;
                        result_d = prep_special_res;
                        cnt_d    = '0;
                        acc_d    = '0;
                    end else begin
                        state_d = ST_CALC;
                        cnt_d   = CW'(NSTEP);
                        acc_d   = {{XLEN{1'b0}}, prep_a_mag};
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d  = ST_DONE;
                    result_d = fin_res;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            result_d = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_mag_q   <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_mag_q   <= b_mag_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec vectors, random ops against an arithmetic model,
// back-pressure, flush and mid-operation reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int NSTEP = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN         (XLEN),
        .BITS_PER_CYC (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural reference: full-precision arithmetic on 64-bit integers
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      uy;
        longint      q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'b0, y});
        case (o)
            3'b000: begin p = 64'(sx * sy);              return p[31:0];  end
            3'b001: begin p = 64'(sx * sy);              return p[63:32]; end
            3'b010: begin p = 64'(sx * uy);              return p[63:32]; end
            3'b011: begin p = {32'b0, x} * {32'b0, y};   return p[63:32]; end
            3'b100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                q = sx / sy;
                return q[31:0];
            end
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 0) return x;
                q = sx % sy;
                return q[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && ((y == 0) || (!o[0] && x == INT_MIN && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return INT_MIN;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one request from IDLE, wait for the result, check latency/value, then retire it
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        op = o;
        a  = x;
        b  = y;
        in_valid = 1'b1;
        check_val({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check_val({tag, "/latency"}, 64'(lat), is_special(o, x, y) ? 64'd0 : 64'(NSTEP));
        check_val({tag, "/result"}, 64'(result), 64'(ref_model(o, x, y)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "/retired"}, {63'd0, out_valid}, 64'd0);
        check_val({tag, "/ready_again"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen;

        #1;
        check_val("reset/in_ready", {63'd0, in_ready}, 64'd1);
        check_val("reset/out_valid", {63'd0, out_valid}, 64'd0);
        check_val("reset/result", 64'(result), 64'd0);
        check_val("reset/busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Directed vectors
        run_op("mul_7_m3",     3'b000, 32'd7, -32'd3);
        run_op("mulh_7_m3",    3'b001, 32'd7, -32'd3);
        run_op("mulhu_ff",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2",     3'b100, -32'd7, 32'd2);
        run_op("rem_m7_2",     3'b110, -32'd7, 32'd2);
        run_op("divu_100_7",   3'b101, 32'd100, 32'd7);
        run_op("remu_100_7",   3'b111, 32'd100, 32'd7);
        run_op("divu_by0",     3'b101, 32'd5, 32'd0);
        run_op("rem_by0",      3'b110, 32'd5, 32'd0);
        run_op("div_ovf",      3'b100, INT_MIN, 32'hFFFF_FFFF);
        run_op("rem_ovf",      3'b110, INT_MIN, 32'hFFFF_FFFF);
        run_op("mulh_min_min", 3'b001, INT_MIN, INT_MIN);
        run_op("divu_ovf_ops", 3'b101, INT_MIN, 32'hFFFF_FFFF);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        // Back-pressure: result holds, new requests are refused
        op = 3'b101; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 200 && !out_valid; n++) tick();
        held = ref_model(3'b101, 32'd100, 32'd7);
        op = 3'b000; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            check_val($sformatf("bp/valid%0d", n), {63'd0, out_valid}, 64'd1);
            check_val($sformatf("bp/result%0d", n), 64'(result), 64'(held));
            check_val($sformatf("bp/in_ready%0d", n), {63'd0, in_ready}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp/in_ready_after", {63'd0, in_ready}, 64'd1);
        check_val("bp/valid_after", {63'd0, out_valid}, 64'd0);
        tick();
        check_val("bp/no_accept", {63'd0, busy}, 64'd0);

        // Flush in the middle of CALC
        op = 3'b000; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check_val("flush/busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush/busy", {63'd0, busy}, 64'd0);
        check_val("flush/in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check_val("flush/no_valid", {63'd0, seen}, 64'd0);
        run_op("flush/mul_3_4", 3'b000, 32'd3, 32'd4);

        // Flush beats a simultaneous request in IDLE
        op = 3'b000; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check_val("flush_idle/busy", {63'd0, busy}, 64'd0);

        // Flush beats a simultaneous out_ready in DONE
        op = 3'b101; a = 32'd5; b = 32'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("flush_done/valid", {63'd0, out_valid}, 64'd1);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check_val("flush_done/valid_after", {63'd0, out_valid}, 64'd0);
        check_val("flush_done/in_ready", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset in the middle of CALC
        op = 3'b011; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mid/in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_mid/out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_mid/result", 64'(result), 64'd0);
        check_val("rst_mid/busy", {63'd0, busy}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op("rst_mid/after", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
